// File: rtl/alu_ctrl_seq_pkg.sv
// Shared constants for the ALU control sequencer: funct codes, alu_op classes,
// select encodings, FSM state type and the per-select latency helper.
package alu_ctrl_pkg;

  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_SRA  = 6'h03;
  localparam logic [5:0] FUNCT_MULT = 6'h18;
  localparam logic [5:0] FUNCT_DIV  = 6'h1A;
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_XOR  = 6'h26;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;

  localparam int unsigned ALUOP_RTYPE = 0;
  localparam int unsigned ALUOP_ADD   = 1;
  localparam int unsigned ALUOP_AND   = 2;
  localparam int unsigned ALUOP_OR    = 3;
  localparam int unsigned ALUOP_SUB   = 4;
  localparam int unsigned ALUOP_SLT   = 5;
  localparam int unsigned ALUOP_XOR   = 6;

  localparam int unsigned SEL_ADD  = 0;
  localparam int unsigned SEL_SUB  = 1;
  localparam int unsigned SEL_AND  = 2;
  localparam int unsigned SEL_OR   = 3;
  localparam int unsigned SEL_SLL  = 4;
  localparam int unsigned SEL_SRL  = 5;
  localparam int unsigned SEL_SLT  = 6;
  localparam int unsigned SEL_XOR  = 7;
  localparam int unsigned SEL_NOR  = 8;
  localparam int unsigned SEL_SRA  = 9;
  localparam int unsigned SEL_MULT = 10;
  localparam int unsigned SEL_DIV  = 11;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Cycles from accept to out_valid; everything outside the MD unit is single-cycle.
  function automatic int unsigned sel_latency(input int unsigned sel,
                                              input int unsigned mul_lat,
                                              input int unsigned div_lat);
    if (sel == SEL_MULT) return mul_lat;
    if (sel == SEL_DIV)  return div_lat;
    return 1;
  endfunction

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// Handshake and result bundle between the ID/EX stage and the ALU control sequencer.
// master = upstream/driver side, slave = the sequencer.
interface alu_ctrl_seq_if #(
  parameter int SEL_W   = 4,
  parameter int ALUOP_W = 3
);
  logic               in_valid;
  logic               in_ready;
  logic [5:0]         funct;
  logic [ALUOP_W-1:0] alu_op;
  logic               flush;
  logic [SEL_W-1:0]   select;
  logic               multicycle;
  logic               out_valid;
  logic               illegal;
  logic               stall;
  logic [15:0]        stall_cnt;

  modport master (
    output in_valid, funct, alu_op, flush,
    input  in_ready, select, multicycle, out_valid, illegal, stall, stall_cnt
  );

  modport slave (
    input  in_valid, funct, alu_op, flush,
    output in_ready, select, multicycle, out_valid, illegal, stall, stall_cnt
  );
endinterface

// File: rtl/alu_ctrl_seq_decode.sv
// Combinational decode of (funct, alu_op) into select / multicycle / illegal.
// Every path assigns select, so an unlisted code always yields select=0.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int SEL_W   = 4,
  parameter int ALUOP_W = 3
) (
  input  logic [5:0]         funct_i,
  input  logic [ALUOP_W-1:0] alu_op_i,
  output logic [SEL_W-1:0]   select_o,
  output logic               multicycle_o,
  output logic               illegal_o
);

  always_comb begin
    select_o     = '0;
    multicycle_o = 1'b0;
    illegal_o    = 1'b0;
    if (alu_op_i == '0) begin
      case (funct_i)
        FUNCT_ADD:  select_o = SEL_W'(SEL_ADD);
        FUNCT_SUB:  select_o = SEL_W'(SEL_SUB);
        FUNCT_AND:  select_o = SEL_W'(SEL_AND);
        FUNCT_OR:   select_o = SEL_W'(SEL_OR);
        FUNCT_SLL:  select_o = SEL_W'(SEL_SLL);
        FUNCT_SRL:  select_o = SEL_W'(SEL_SRL);
        FUNCT_SLT:  select_o = SEL_W'(SEL_SLT);
        FUNCT_XOR:  select_o = SEL_W'(SEL_XOR);
        FUNCT_NOR:  select_o = SEL_W'(SEL_NOR);
        FUNCT_SRA:  select_o = SEL_W'(SEL_SRA);
        FUNCT_MULT: begin
          select_o     = SEL_W'(SEL_MULT);
          multicycle_o = 1'b1;
        end
        FUNCT_DIV: begin
          select_o     = SEL_W'(SEL_DIV);
          multicycle_o = 1'b1;
        end
        default:    illegal_o = 1'b1;
      endcase
    end else begin
      case (32'(alu_op_i))
        ALUOP_ADD: select_o = SEL_W'(SEL_ADD);
        ALUOP_AND: select_o = SEL_W'(SEL_AND);
        ALUOP_OR:  select_o = SEL_W'(SEL_OR);
        ALUOP_SUB: select_o = SEL_W'(SEL_SUB);
        ALUOP_SLT: select_o = SEL_W'(SEL_SLT);
        ALUOP_XOR: select_o = SEL_W'(SEL_XOR);
        default:   illegal_o = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU control sequencer: registers the decoded select and sequences mult/div with a
// busy counter that drives the pipeline stall. Optional macro ALU_CTRL_SEQ_STALL_CNT_EN.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int          SEL_W   = 4,
  parameter int          ALUOP_W = 3,
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 32
) (
  input logic           clk,
  input logic           rst,
  alu_ctrl_seq_if.slave bus
);

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int          CNT_W   = $clog2(MAX_LAT);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [SEL_W-1:0]   select_q;
  logic               multicycle_q;
  logic               illegal_q;
  logic               out_valid_q;

  logic [SEL_W-1:0]   dec_select;
  logic               dec_multicycle;
  logic               dec_illegal;
  logic               accept;
  logic [CNT_W-1:0]   load_d;

  alu_ctrl_decode #(
    .SEL_W   (SEL_W),
    .ALUOP_W (ALUOP_W)
  ) u_decode (
    .funct_i      (bus.funct),
    .alu_op_i     (bus.alu_op),
    .select_o     (dec_select),
    .multicycle_o (dec_multicycle),
    .illegal_o    (dec_illegal)
  );

  assign accept = bus.in_valid & (state_q == IDLE) & ~bus.flush;
  assign load_d = CNT_W'(sel_latency(32'(dec_select), MUL_LAT, DIV_LAT) - 1);

  // out_valid is raised on the edge where the counter steps 1->0, so it is visible
  // in the LAT-th cycle after accept; the following edge returns to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      select_q     <= '0;
      multicycle_q <= 1'b0;
      illegal_q    <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            select_q     <= dec_select;
            multicycle_q <= dec_multicycle;
            illegal_q    <= dec_illegal;
            if (dec_multicycle) begin
              state_q <= BUSY;
              cnt_q   <= load_d;
            end else begin
              out_valid_q <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (bus.flush) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == '0) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) out_valid_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.stall      = (state_q == BUSY);
  assign bus.select     = select_q;
  assign bus.multicycle = multicycle_q;
  assign bus.illegal    = illegal_q;
  assign bus.out_valid  = out_valid_q;

`ifdef ALU_CTRL_SEQ_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  // Saturating count of stalled cycles, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if ((state_q == BUSY) && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
`else
  assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: expected results are queued when an op is
// driven and compared (including latency) whenever out_valid is seen.
module tb_alu_ctrl_seq;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;

  typedef struct {
    logic [3:0] sel;
    logic       mc;
    logic       ill;
    int         lat;
    int         due;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checkCount;
  int   failCount;
  exp_t sbQ[$];
  exp_t monE;
  int   expStallCnt;

  alu_ctrl_seq_if #(.SEL_W(4), .ALUOP_W(3)) bus ();

  alu_ctrl_seq #(
    .SEL_W   (4),
    .ALUOP_W (3),
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Independent reference table for the decode.
  function automatic exp_t modelDecode(input logic [2:0] aluOp, input logic [5:0] f);
    exp_t e;
    e.sel = 4'd0; e.mc = 1'b0; e.ill = 1'b0; e.lat = 1; e.due = 0;
    if (aluOp == 3'd0) begin
      case (f)
        6'h20: e.sel = 4'd0;
        6'h22: e.sel = 4'd1;
        6'h24: e.sel = 4'd2;
        6'h25: e.sel = 4'd3;
        6'h00: e.sel = 4'd4;
        6'h02: e.sel = 4'd5;
        6'h2A: e.sel = 4'd6;
        6'h26: e.sel = 4'd7;
        6'h27: e.sel = 4'd8;
        6'h03: e.sel = 4'd9;
        6'h18: begin e.sel = 4'd10; e.mc = 1'b1; e.lat = MUL_LAT; end
        6'h1A: begin e.sel = 4'd11; e.mc = 1'b1; e.lat = DIV_LAT; end
        default: e.ill = 1'b1;
      endcase
    end else begin
      case (aluOp)
        3'd1: e.sel = 4'd0;
        3'd2: e.sel = 4'd2;
        3'd3: e.sel = 4'd3;
        3'd4: e.sel = 4'd1;
        3'd5: e.sel = 4'd6;
        3'd6: e.sel = 4'd7;
        default: e.ill = 1'b1;
      endcase
    end
    return e;
  endfunction

  // Drives one op for one cycle; an op expected to be accepted gets a scoreboard entry.
  task automatic applyStimulus(input logic [2:0] aluOp, input logic [5:0] f, input bit expectAccept);
    exp_t e;
    bus.in_valid = 1'b1;
    bus.alu_op   = aluOp;
    bus.funct    = f;
    if (expectAccept) begin
      checkOutput("inReady", 32'(bus.in_ready), 32'd1);
      e     = modelDecode(aluOp, f);
      e.due = cyc + e.lat;
      sbQ.push_back(e);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while (sbQ.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sbQ.size() != 0) begin
      checkOutput("drainTimeout", 32'(sbQ.size()), 32'd0);
      sbQ.delete();
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (bus.out_valid) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpectedOutValid", 32'd1, 32'd0);
      end else begin
        monE = sbQ.pop_front();
        checkOutput("select", 32'(bus.select), 32'(monE.sel));
        checkOutput("multicycle", 32'(bus.multicycle), 32'(monE.mc));
        checkOutput("illegal", 32'(bus.illegal), 32'(monE.ill));
        checkOutput("latencyCycle", 32'(cyc), 32'(monE.due));
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checkCount   = 0;
    failCount    = 0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.funct    = 6'h00;
    bus.alu_op   = 3'd0;
    bus.flush    = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rstSelect", 32'(bus.select), 32'd0);
    checkOutput("rstOutValid", 32'(bus.out_valid), 32'd0);
    checkOutput("rstIllegal", 32'(bus.illegal), 32'd0);
    checkOutput("rstMulticycle", 32'(bus.multicycle), 32'd0);
    checkOutput("rstStall", 32'(bus.stall), 32'd0);
    checkOutput("rstInReady", 32'(bus.in_ready), 32'd1);
    checkOutput("rstStallCnt", 32'(bus.stall_cnt), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] single-cycle sub");
    applyStimulus(3'd0, 6'h22, 1'b1);
    checkOutput("subStall", 32'(bus.stall), 32'd0);
    waitDrain(5);

    $display("[TB] mult with ignored in_valid while busy");
    applyStimulus(3'd0, 6'h18, 1'b1);
    for (int i = 0; i < MUL_LAT; i++) begin
      checkOutput("mulStall", 32'(bus.stall), 32'd1);
      checkOutput("mulInReady", 32'(bus.in_ready), 32'd0);
      bus.in_valid = (i == 1);
      bus.alu_op   = 3'd1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    checkOutput("mulDoneStall", 32'(bus.stall), 32'd0);
    checkOutput("mulDoneInReady", 32'(bus.in_ready), 32'd1);
    checkOutput("mulHeldSelect", 32'(bus.select), 32'd10);
    checkOutput("mulHeldMulticycle", 32'(bus.multicycle), 32'd1);
    waitDrain(5);

    $display("[TB] div flushed five cycles in");
    applyStimulus(3'd0, 6'h1A, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("divStallBeforeFlush", 32'(bus.stall), 32'd1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    checkOutput("flushStall", 32'(bus.stall), 32'd0);
    checkOutput("flushInReady", 32'(bus.in_ready), 32'd1);
    checkOutput("flushSelectKept", 32'(bus.select), 32'd11);
    applyStimulus(3'd0, 6'h20, 1'b1);
    waitDrain(5);
    repeat (DIV_LAT + 4) @(negedge clk);

    $display("[TB] illegal codes");
    applyStimulus(3'd7, 6'h20, 1'b1);
    applyStimulus(3'd0, 6'h3F, 1'b1);
    waitDrain(5);

    $display("[TB] back-to-back alu_op classes");
    applyStimulus(3'd1, 6'h22, 1'b1);
    applyStimulus(3'd2, 6'h22, 1'b1);
    applyStimulus(3'd3, 6'h22, 1'b1);
    applyStimulus(3'd5, 6'h22, 1'b1);
    waitDrain(6);

    $display("[TB] flush in IDLE drops input, pending out_valid fires");
    applyStimulus(3'd0, 6'h24, 1'b1);
    bus.in_valid = 1'b1;
    bus.funct    = 6'h22;
    bus.flush    = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    checkOutput("idleFlushSelect", 32'(bus.select), 32'd2);
    checkOutput("idleFlushOutValid", 32'(bus.out_valid), 32'd0);
    waitDrain(5);

    $display("[TB] full R-type sweep");
    begin
      logic [5:0] sweep[14];
      sweep = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h00, 6'h02, 6'h2A,
                6'h26, 6'h27, 6'h03, 6'h18, 6'h1A, 6'h01, 6'h3F};
      for (int i = 0; i < 14; i++) begin
        applyStimulus(3'd0, sweep[i], 1'b1);
        waitDrain(DIV_LAT + 4);
      end
      applyStimulus(3'd4, 6'h00, 1'b1);
      applyStimulus(3'd6, 6'h00, 1'b1);
      waitDrain(5);
    end

    $display("[TB] reset in the middle of a div");
    applyStimulus(3'd0, 6'h1A, 1'b0);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midRstStall", 32'(bus.stall), 32'd0);
    checkOutput("midRstSelect", 32'(bus.select), 32'd0);
    checkOutput("midRstInReady", 32'(bus.in_ready), 32'd1);
    checkOutput("midRstStallCnt", 32'(bus.stall_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (DIV_LAT + 4) @(negedge clk);

    $display("[TB] three mults for the stall counter");
    repeat (3) begin
      applyStimulus(3'd0, 6'h18, 1'b1);
      waitDrain(MUL_LAT + 4);
    end
`ifdef ALU_CTRL_SEQ_STALL_CNT_EN
    expStallCnt = 3 * MUL_LAT;
`else
    expStallCnt = 0;
`endif
    checkOutput("stallCnt", 32'(bus.stall_cnt), 32'(expStallCnt));
    #2 rst = 1'b1;
    #1;
    checkOutput("finalRstStallCnt", 32'(bus.stall_cnt), 32'd0);
    checkOutput("finalRstStall", 32'(bus.stall), 32'd0);
    checkOutput("finalRstInReady", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    checkOutput("scoreboardEmpty", 32'(sbQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
- Parametrised successor of the single-stage ALU control decoder.
- Decodes R-type funct or main-control alu_op into an ALU/MD-unit select code with a valid handshake.
- Sequences multi-cycle ops (mult, div) with a busy counter and drives the pipeline stall.
- Sits between the ID/EX register and the ALU / multiply-divide unit.

Parameters:
SEL_W, 4, width of select output (minimum 4)
ALUOP_W, 3, width of alu_op input
MUL_LAT, 4, cycles from accept to out_valid for mult (2 or more)
DIV_LAT, 32, cycles from accept to out_valid for div (2 or more)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  funct/alu_op valid this cycle
in_ready  out  1  block can accept; equals ~stall
funct  in  6  R-type function field
alu_op  in  ALUOP_W  main-control ALU op class
flush  in  1  abort current op, drop input this cycle
select  out  SEL_W  registered ALU/MD select
multicycle  out  1  registered; select targets MD unit
out_valid  out  1  one-cycle pulse, op result usable
illegal  out  1  registered; qualified by out_valid
stall  out  1  high while BUSY
stall_cnt  out  16  stall-cycle count (see Optional Feature)

Behaviour:
- Interface: one clock clk; reset rst is asynchronous and active-high.
- Reset values: state=IDLE, select=0, multicycle=0, out_valid=0, illegal=0, stall=0, counter=0, stall_cnt=0.
- Decode, alu_op==0 (funct→select): 0x20 add→0; 0x22 sub→1; 0x24 and→2; 0x25 or→3; 0x00 sll→4; 0x02 srl→5; 0x2A slt→6; 0x26 xor→7; 0x27 nor→8; 0x03 sra→9; 0x18 mult→10 (multicycle); 0x1A div→11 (multicycle).
- Decode, alu_op≠0: 1→0 (add, lw/sw/addi); 2→2 (andi); 3→3 (ori); 4→1 (sub, beq); 5→6 (slti); 6→7 (xori); 7→illegal.
- Unlisted funct or alu_op: select=0, multicycle=0, illegal=1. Select is never left holding a stale value.
- Accept: in_valid & in_ready & ~flush. select, multicycle and illegal are registered on accept and held until the next accept.
- FSM state IDLE: in_ready=1.
  - Accept of a single-cycle or illegal op: out_valid=1 on the next cycle (latency 1); stay in IDLE.
  - Accept of a multi-cycle op: go to BUSY; counter loads LAT-1.
- FSM state BUSY: in_ready=0, stall=1.
  - Counter decrements each cycle.
  - When counter==0: out_valid=1 that cycle, state→IDLE next cycle.
  - Net result: out_valid rises exactly LAT cycles after the accept edge.
- Back-to-back single-cycle accepts give out_valid high on consecutive cycles.
- in_valid while BUSY is ignored; upstream must hold.
- flush:
  - In BUSY: next state IDLE, counter cleared, no out_valid; select retained.
  - In IDLE: flush wins over in_valid; input dropped; a pending out_valid still fires.
- Counter width: $clog2(max(MUL_LAT,DIV_LAT)). No wrap, because load ≤ LAT-1.
- rst mid-BUSY: immediate return to reset values, no out_valid.

Optional Feature:
- Macro: ALU_CTRL_SEQ_STALL_CNT_EN.
- Defined: stall_cnt increments on every cycle stall=1, saturates at 0xFFFF, and clears only on rst.
- Undefined: no counter logic; stall_cnt tied to 0.

Decomposition:
- Package alu_ctrl_pkg:
  - funct constants (FUNCT_ADD…FUNCT_DIV)
  - alu_op codes
  - select encodings (SEL_ADD=0…SEL_DIV=11)
  - state enum {IDLE, BUSY}
  - helper function returning latency per select
- Sub-module alu_ctrl_decode: purely combinational table (funct, alu_op → select, multicycle, illegal), instantiated once. The FSM and counter live in the top.

Test Plan:
- Reset then alu_op=0, funct=0x22, in_valid one cycle → next cycle select=1, out_valid=1, stall=0.
- alu_op=0, funct=0x18, MUL_LAT=4 → stall=1 for 4 cycles, in_ready=0, out_valid on 4th cycle after accept, select=10, multicycle=1; IDLE after.
- funct=0x1A (div), flush asserted 5 cycles in → stall drops next cycle, no out_valid, next add accepted normally with select=0.
- alu_op=7, then alu_op=0/funct=0x3F → out_valid=1, illegal=1, select=0 both times.
- Back-to-back accepts alu_op=1,2,3,5 → out_valid high 4 consecutive cycles with select 0,2,3,6.
- rst pulsed mid-div; with ALU_CTRL_SEQ_STALL_CNT_EN, run 3 mults (MUL_LAT=4) → stall_cnt=12; after rst, stall_cnt=0, state IDLE.
